// File: rtl/taxi_wheel_driver_pkg.sv
// Shared taxi meter types and default wheel divider rates.
// Used by the wheel driver and the fare/distance blocks.
package taxi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_e;

  localparam int HIGH_DIV_DEF = 5;
  localparam int LOW_DIV_DEF  = 50;

  function automatic int div_for(
    input logic hi,
    input int   high_div,
    input int   low_div
  );
    return hi ? high_div : low_div;
  endfunction

endpackage

// File: rtl/taxi_wheel_driver_if.sv
// Driver-button and distance-signal bundle of the wheel driver.
// master = button/stimulus side, slave = wheel driver.
interface taxi_wheel_driver_if #(
  parameter int CNT_W = 17
);
  logic             start_btn;
  logic             pause_btn;
  logic             stop_btn;
  logic             speed_sel;
  logic             wheel_clk;
  logic             high_speed;
  logic             low_speed;
  logic             pause_state;
  logic             stop_state;
  logic [CNT_W-1:0] wheel_count;

  modport master (
    output start_btn,
    output pause_btn,
    output stop_btn,
    output speed_sel,
    input  wheel_clk,
    input  high_speed,
    input  low_speed,
    input  pause_state,
    input  stop_state,
    input  wheel_count
  );

  modport slave (
    input  start_btn,
    input  pause_btn,
    input  stop_btn,
    input  speed_sel,
    output wheel_clk,
    output high_speed,
    output low_speed,
    output pause_state,
    output stop_state,
    output wheel_count
  );
endinterface

// File: rtl/taxi_btn_edge.sv
// Button history register and rising-edge detect.
// History resets to 1 so a button held through reset does not fire.
module taxi_btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);

  logic hist_q;

  // remember last cycle's button level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= 1'b1;
    else        hist_q <= btn_i;
  end

  assign rise_o = btn_i & ~hist_q;

endmodule

// File: rtl/taxi_wheel_driver.sv
// Taxi wheel driver: button FSM plus speed-dependent wheel_clk
// divider and running wheel-edge count.
module taxi_wheel_driver
  import taxi_pkg::*;
#(
  parameter int HIGH_DIV = HIGH_DIV_DEF,
  parameter int LOW_DIV  = LOW_DIV_DEF,
  parameter int DIV_W    = 16,
  parameter int CNT_W    = 17
) (
  input  logic clk,
  input  logic rst_n,
  taxi_wheel_driver_if.slave bus
);

  localparam logic [DIV_W-1:0] HI_TOP = DIV_W'(HIGH_DIV - 1);
  localparam logic [DIV_W-1:0] LO_TOP = DIV_W'(LOW_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] div_top;
  logic             wclk_q, wclk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             spd_q;
  logic             start_e, pause_e, stop_e;

  taxi_btn_edge u_start (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (bus.start_btn),
    .rise_o (start_e)
  );

  taxi_btn_edge u_pause (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (bus.pause_btn),
    .rise_o (pause_e)
  );

  taxi_btn_edge u_stop (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (bus.stop_btn),
    .rise_o (stop_e)
  );

  assign div_top = bus.speed_sel ? HI_TOP : LO_TOP;

  // trip FSM and wheel divider next-state
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    wclk_d  = wclk_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_e) begin
          state_d = RUN;
          div_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (stop_e || pause_e) begin
          state_d = stop_e ? IDLE : PAUSED;
          wclk_d  = 1'b0;
          div_d   = '0;
        end else if (bus.speed_sel != spd_q) begin
          div_d = '0;
        end else if (div_q >= div_top) begin
          div_d  = '0;
          wclk_d = ~wclk_q;
          if (!wclk_q) cnt_d = cnt_q + CNT_ONE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      PAUSED: begin
        if (stop_e) begin
          state_d = IDLE;
        end else if (start_e || pause_e) begin
          state_d = RUN;
          div_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        wclk_d  = 1'b0;
        div_d   = '0;
      end
    endcase
  end

  // state, divider, wheel level, count and speed history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      wclk_q  <= 1'b0;
      cnt_q   <= '0;
      spd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      wclk_q  <= wclk_d;
      cnt_q   <= cnt_d;
      spd_q   <= bus.speed_sel;
    end
  end

  assign bus.wheel_clk   = wclk_q;
  assign bus.wheel_count = cnt_q;
  assign bus.stop_state  = (state_q == IDLE);
  assign bus.pause_state = (state_q == PAUSED);
  assign bus.high_speed  = (state_q == RUN) & spd_q;
  assign bus.low_speed   = (state_q == RUN) & ~spd_q;

endmodule

// File: doc/taxi_wheel_driver.md
Name: taxi_wheel_driver

Overview:
Stimulus/producer side of the taxi meter's distance interface. Turns driver buttons (start, pause, stop) and a speed selector into the `wheel_clk`, `high_speed`, `low_speed`, `pause_state` and `stop_state` signals the distance/low-speed-time counter consumes. Generates `wheel_clk` as a divided-down square wave whose rate depends on the selected speed. Also reports a running wheel-edge count for cross-checking the distance block.

Parameters:
- HIGH_DIV, 5, clk cycles per `wheel_clk` half-period at high speed (>=1)
- LOW_DIV, 50, clk cycles per `wheel_clk` half-period at low speed (>=1)
- DIV_W, 16, width of the divider counter; must hold max(HIGH_DIV, LOW_DIV)-1
- CNT_W, 17, width of `wheel_count`

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- start_btn  in  1  level; a rising edge starts or resumes the trip
- pause_btn  in  1  level; a rising edge toggles pause
- stop_btn  in  1  level; a rising edge ends the trip
- speed_sel  in  1  1 = high speed, 0 = low speed
- wheel_clk  out  1  simulated wheel rotation square wave
- high_speed  out  1  running at high speed
- low_speed  out  1  running at low speed
- pause_state  out  1  trip paused
- stop_state  out  1  no trip in progress
- wheel_count  out  CNT_W  `wheel_clk` rising edges since trip start, wraps modulo 2^CNT_W

Behaviour:
- One clock domain: `clk`. Reset is asynchronous and active-low (`rst_n`). All outputs are registered or decoded directly from registers.
- Reset values:
  - state = IDLE
  - `stop_state` = 1; `wheel_clk`, `high_speed`, `low_speed`, `pause_state` = 0
  - `wheel_count` = 0, div_cnt = 0
  - button history registers = 1, so buttons held through reset do not fire
  - speed_q = 0
- Edge detect: `x_edge = x_btn & ~x_q`, where x_q is `x_btn` registered every cycle.
- FSM states: IDLE, RUN, PAUSED. Priority within a cycle: stop > pause > start.
  - IDLE:
    - `start_edge` -> RUN; clear div_cnt and `wheel_count`
    - `pause_edge` and `stop_edge` are ignored
  - RUN:
    - `stop_edge` -> IDLE
    - else `pause_edge` -> PAUSED (also when start and pause arrive together)
    - `start_edge` alone is ignored
  - PAUSED:
    - `stop_edge` -> IDLE
    - else `start_edge` or `pause_edge` -> RUN; div_cnt cleared, `wheel_count` kept
- Output decode:
  - `stop_state` = (state == IDLE)
  - `pause_state` = (state == PAUSED)
  - `high_speed` = RUN & `speed_sel`
  - `low_speed` = RUN & ~`speed_sel`
  - Status changes are visible in the cycle after the clock edge that detects the button edge.
- Divider, active only in RUN:
  - DIV = `speed_sel` ? HIGH_DIV : LOW_DIV.
  - Each cycle: if div_cnt == DIV-1, toggle `wheel_clk` and set div_cnt = 0; else increment div_cnt.
  - Period is 2*DIV cycles. First rising edge comes DIV cycles after RUN entry.
  - On the toggle 0->1, `wheel_count` increments on the same clock edge.
- Speed change in RUN (`speed_sel` != speed_q): div_cnt = 0 that cycle, no toggle, `wheel_clk` level held.
  - speed_q is registered every cycle.
- Leaving RUN (to PAUSED or IDLE): `wheel_clk` forced to 0 on the transition edge and div_cnt = 0.
  - The falling edge this produces is legal; no count change.
- Entering IDLE: `wheel_count` is held until the next start, where it clears. The distance block clears its own state on `stop_state`.
- `wheel_count` at all-ones wraps to 0 on the next rising edge.
- Reset asserted mid-trip: all registers return to reset values immediately and asynchronously.

Decomposition:
- Shared package taxi_pkg:
  - state enum: IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2
  - default HIGH_DIV/LOW_DIV constants, shared with the fare/distance blocks
- One sub-module, taxi_btn_edge: per-button history register plus rising-edge detect, reset to 1. Instantiated three times.
- The divider and FSM stay in the top module.

Test Plan:
1. Reset released with `start_btn` held high -> stays IDLE, `stop_state` = 1, `wheel_clk` = 0. Release, then press start -> `stop_state` = 0 and `low_speed` = 1 one cycle later; first `wheel_clk` rise after 50 cycles, period 100.
2. `speed_sel` = 1, start, run 1000 cycles with HIGH_DIV = 5 -> 100 rising edges, `wheel_count` = 100, `high_speed` = 1, `low_speed` = 0.
3. Pause while `wheel_clk` = 1 -> `wheel_clk` = 0 next cycle, `pause_state` = 1, both speed flags 0, count frozen. Press pause again -> RUN, count resumes from the frozen value, next rise DIV cycles later.
4. `stop_btn` and `pause_btn` rise in the same cycle during RUN -> IDLE, `stop_state` = 1. Next start clears `wheel_count` to 0.
5. Toggle `speed_sel` 0->1 mid-RUN with div_cnt = 30 -> no toggle that cycle, level held, next toggle exactly 5 cycles later.
6. CNT_W = 4: run 17 rising edges -> `wheel_count` = 1 (wrap). Assert `rst_n` low mid-run -> all outputs reach reset values without waiting for a clock edge.
